// File: rtl/fifo_le_fwft_if.sv
// Handshake/data bundle for fifo_le_fwft: the FIFO sits on the slave modport,
// and the producer/consumer logic sits on the master modport.
interface fifo_le_fwft_if #(
  parameter int unsigned ADDR  = 4,
  parameter int unsigned WIDTH = 8
);
  logic             fifoflsh;
  logic             fifowr;
  logic [WIDTH-1:0] fifodin;
  logic             fiford;
  logic [WIDTH-1:0] fifodout;
  logic             fifovld;
  logic [ADDR:0]    fifolen;
  logic             fifofull;
  logic             fifoempt;
  logic             afull;
  logic             aempt;
  logic             ovf;
  logic             udf;

  modport master (
    output fifoflsh, fifowr, fifodin, fiford,
    input  fifodout, fifovld, fifolen, fifofull, fifoempt, afull, aempt, ovf, udf
  );

  modport slave (
    input  fifoflsh, fifowr, fifodin, fiford,
    output fifodout, fifovld, fifolen, fifofull, fifoempt, afull, aempt, ovf, udf
  );
endinterface

// File: rtl/fifo_le_fwft.sv
// Single-clock LE-register FIFO with optional first-word-fall-through output,
// occupancy count, almost-full/empty flags; FIFO_LE_FWFT_ERR_EN adds sticky ovf/udf.
module fifo_le_fwft #(
  parameter int unsigned ADDR      = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SHOWAHEAD = 0,
  parameter int unsigned AFULL_TH  = 2**ADDR - 2,
  parameter int unsigned AEMPT_TH  = 2
) (
  input logic           clk,
  input logic           rst,
  fifo_le_fwft_if.slave fif
);

  localparam int unsigned   DEPTH    = 2**ADDR;
  localparam logic [ADDR:0] LEN_FULL = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] LEN_AF   = (ADDR+1)'(AFULL_TH);
  localparam logic [ADDR:0] LEN_AE   = (ADDR+1)'(AEMPT_TH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR-1:0]  wr_ptr;
  logic [ADDR-1:0]  rd_ptr;
  logic [ADDR:0]    len_q;
  logic [WIDTH-1:0] dout_q;
  logic             vld_q;

  logic             full;
  logic             empt;
  logic             wrstrobe;
  logic             rdstrobe;
  logic             load;
  logic             udf_cond;
  logic [ADDR:0]    mem_cnt;

  // In show-ahead mode the output register holds one of the counted words, so
  // the array only holds len_q - vld_q; it refills whenever the head is free.
  always_comb begin
    full     = (len_q == LEN_FULL);
    empt     = (len_q == '0);
    wrstrobe = fif.fifowr & ~full;
    mem_cnt  = len_q - {{ADDR{1'b0}}, vld_q};
    if (SHOWAHEAD != 0) begin
      rdstrobe = fif.fiford & vld_q;
      udf_cond = fif.fiford & ~vld_q;
      load     = (~vld_q | rdstrobe) & (mem_cnt != '0);
    end else begin
      rdstrobe = fif.fiford & ~empt;
      udf_cond = fif.fiford & empt;
      load     = rdstrobe;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      len_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else if (fif.fifoflsh) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      len_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      if (wrstrobe) begin
        wr_ptr <= wr_ptr + ADDR'(1);
      end
      if (load) begin
        rd_ptr <= rd_ptr + ADDR'(1);
        dout_q <= mem[rd_ptr];
      end
      case ({wrstrobe, rdstrobe})
        2'b10:   len_q <= len_q + (ADDR+1)'(1);
        2'b01:   len_q <= len_q - (ADDR+1)'(1);
        default: len_q <= len_q;
      endcase
      if (SHOWAHEAD != 0) begin
        if (load) begin
          vld_q <= 1'b1;
        end else if (rdstrobe) begin
          vld_q <= 1'b0;
        end
      end else begin
        vld_q <= rdstrobe;
      end
    end
  end

  // Storage is not reset; discarding content only needs the pointers cleared.
  always_ff @(posedge clk) begin
    if (!rst && !fif.fifoflsh && wrstrobe) begin
      mem[wr_ptr] <= fif.fifodin;
    end
  end

`ifdef FIFO_LE_FWFT_ERR_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clk) begin
    if (rst || fif.fifoflsh) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (fif.fifowr && full) begin
        ovf_q <= 1'b1;
      end
      if (udf_cond) begin
        udf_q <= 1'b1;
      end
    end
  end

  assign fif.ovf = ovf_q;
  assign fif.udf = udf_q;
`else
  logic unused_udf;
  assign unused_udf = udf_cond;
  assign fif.ovf    = 1'b0;
  assign fif.udf    = 1'b0;
`endif

  assign fif.fifodout = dout_q;
  assign fif.fifovld  = vld_q;
  assign fif.fifolen  = len_q;
  assign fif.fifofull = full;
  assign fif.fifoempt = empt;
  assign fif.afull    = (len_q >= LEN_AF);
  assign fif.aempt    = (len_q <= LEN_AE);

endmodule

// File: tb/tb_fifo_le_fwft.sv
// Directed bench: dut_a is a 4-deep registered-read FIFO (AFULL_TH=3, AEMPT_TH=1),
// dut_b a 4-deep show-ahead FIFO with default thresholds (2/2).
module tb_fifo_le_fwft;

`ifdef FIFO_LE_FWFT_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  fifo_le_fwft_if #(.ADDR(2), .WIDTH(8)) ifa ();
  fifo_le_fwft_if #(.ADDR(2), .WIDTH(8)) ifb ();

  fifo_le_fwft #(.ADDR(2), .WIDTH(8), .SHOWAHEAD(0), .AFULL_TH(3), .AEMPT_TH(1))
    dut_a (.clk(clk), .rst(rst), .fif(ifa.slave));

  fifo_le_fwft #(.ADDR(2), .WIDTH(8), .SHOWAHEAD(1))
    dut_b (.clk(clk), .rst(rst), .fif(ifb.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st_a(input string tag, input logic vld, input logic [7:0] dout, input int len);
    check({tag, ".vld"},  32'(ifa.fifovld),  32'(vld));
    check({tag, ".dout"}, 32'(ifa.fifodout), 32'(dout));
    check({tag, ".len"},  32'(ifa.fifolen),  32'(len));
    check({tag, ".full"}, 32'(ifa.fifofull), 32'(len == 4));
    check({tag, ".empt"}, 32'(ifa.fifoempt), 32'(len == 0));
    check({tag, ".af"},   32'(ifa.afull),    32'(len >= 3));
    check({tag, ".ae"},   32'(ifa.aempt),    32'(len <= 1));
  endtask

  task automatic st_b(input string tag, input logic vld, input logic [7:0] dout, input int len);
    check({tag, ".vld"},  32'(ifb.fifovld),  32'(vld));
    if (vld) check({tag, ".dout"}, 32'(ifb.fifodout), 32'(dout));
    check({tag, ".len"},  32'(ifb.fifolen),  32'(len));
    check({tag, ".full"}, 32'(ifb.fifofull), 32'(len == 4));
    check({tag, ".empt"}, 32'(ifb.fifoempt), 32'(len == 0));
    check({tag, ".af"},   32'(ifb.afull),    32'(len >= 2));
    check({tag, ".ae"},   32'(ifb.aempt),    32'(len <= 2));
  endtask

  task automatic drv_a(input logic fl, input logic wr, input logic rd, input logic [7:0] d);
    ifa.fifoflsh = fl; ifa.fifowr = wr; ifa.fiford = rd; ifa.fifodin = d;
  endtask

  task automatic drv_b(input logic wr, input logic rd, input logic [7:0] d);
    ifb.fifoflsh = 1'b0; ifb.fifowr = wr; ifb.fiford = rd; ifb.fifodin = d;
  endtask

  initial begin
    logic [7:0] wv [4];
    n_vec = 0;
    n_err = 0;
    clk = 1'b0;
    rst = 1'b1;
    drv_a(0, 0, 0, 8'h00);
    drv_b(0, 0, 8'h00);
    tick();
    rst = 1'b0;
    st_a("rst_a", 0, 8'h00, 0);
    check("rst_a.ovf", 32'(ifa.ovf), 0);
    check("rst_a.udf", 32'(ifa.udf), 0);
    st_b("rst_b", 0, 8'h00, 0);
    check("rst_b.dout", 32'(ifb.fifodout), 0);

    // Fill to full, then one rejected write
    wv[0] = 8'h11; wv[1] = 8'h22; wv[2] = 8'h33; wv[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      drv_a(0, 1, 0, wv[i]); tick();
      st_a("fill", 0, 8'h00, i + 1);
    end
    drv_a(0, 1, 0, 8'h55); tick();
    st_a("ovfwr", 0, 8'h00, 4);
    check("ovf_set", 32'(ifa.ovf), 32'(ERR));
    for (int i = 0; i < 4; i++) begin
      drv_a(0, 0, 1, 8'h00); tick();
      st_a("rd", 1, wv[i], 3 - i);
    end
    tick();
    st_a("rd_empty", 0, 8'h44, 0);
    check("udf_set", 32'(ifa.udf), 32'(ERR));

    // rd+wr while empty: write wins; then fill, rd+wr while full: read wins
    drv_a(0, 1, 1, 8'h66); tick();
    st_a("rw_empty", 0, 8'h44, 1);
    wv[0] = 8'h77; wv[1] = 8'h88; wv[2] = 8'h99;
    for (int i = 0; i < 3; i++) begin
      drv_a(0, 1, 0, wv[i]); tick();
      st_a("fill2", 0, 8'h44, i + 2);
    end
    drv_a(0, 1, 1, 8'hAA); tick();
    st_a("rw_full", 1, 8'h66, 3);
    for (int i = 0; i < 3; i++) begin
      drv_a(0, 0, 1, 8'h00); tick();
      st_a("rd2", 1, wv[i], 2 - i);
    end
    drv_a(0, 0, 0, 8'h00); tick();
    st_a("idle", 0, 8'h99, 0);

    // Sustained transfers across three pointer wraps
    drv_a(0, 1, 0, 8'hC0); tick();
    st_a("wrap_pre", 0, 8'h99, 1);
    for (int i = 1; i <= 12; i++) begin
      drv_a(0, 1, 1, 8'(8'hC0 + i)); tick();
      st_a("wrap", 1, 8'(8'hC0 + i - 1), 1);
    end
    drv_a(0, 0, 1, 8'h00); tick();
    st_a("wrap_end", 1, 8'hCC, 0);

    // Flush at len 3 with rd/wr asserted
    for (int i = 0; i < 3; i++) begin
      drv_a(0, 1, 0, 8'(8'hD1 + i)); tick();
    end
    st_a("pre_flush", 0, 8'hCC, 3);
    check("pre_flush.ovf", 32'(ifa.ovf), 32'(ERR));
    drv_a(1, 1, 1, 8'hEE); tick();
    st_a("flush", 0, 8'hCC, 0);
    check("flush.ovf", 32'(ifa.ovf), 0);
    check("flush.udf", 32'(ifa.udf), 0);
    drv_a(0, 0, 0, 8'h00); tick();
    st_a("post_flush", 0, 8'hCC, 0);
    drv_a(0, 1, 0, 8'hF1); tick();
    drv_a(0, 0, 1, 8'h00); tick();
    st_a("post_flush_rd", 1, 8'hF1, 0);

    // Reset with two words held
    drv_a(0, 1, 0, 8'h5A); tick();
    drv_a(0, 1, 0, 8'h5B); tick();
    drv_a(0, 1, 0, 8'h5C); tick();
    drv_a(0, 1, 0, 8'h5D); tick();
    drv_a(0, 1, 0, 8'h5E); tick();
    drv_a(0, 0, 1, 8'h00); tick();
    drv_a(0, 0, 1, 8'h00); tick();
    st_a("pre_rst", 1, 8'h5B, 2);
    check("pre_rst.ovf", 32'(ifa.ovf), 32'(ERR));
    drv_a(0, 0, 0, 8'h00);
    rst = 1'b1; tick(); rst = 1'b0;
    st_a("mid_rst", 0, 8'h00, 0);
    check("mid_rst.ovf", 32'(ifa.ovf), 0);
    check("mid_rst.udf", 32'(ifa.udf), 0);

    // Show-ahead: 2-cycle write-to-visible, pop
    drv_b(1, 0, 8'hA5); tick();
    st_b("fw_wr", 0, 8'h00, 1);
    drv_b(0, 0, 8'h00); tick();
    st_b("fw_vis", 1, 8'hA5, 1);
    drv_b(0, 1, 8'h00); tick();
    st_b("fw_pop", 0, 8'h00, 0);
    tick();
    st_b("fw_udf", 0, 8'h00, 0);
    check("fw_udf.udf", 32'(ifb.udf), 32'(ERR));

    // Show-ahead sustained rd+wr, no bubbles
    drv_b(1, 0, 8'hB0); tick();
    st_b("fw_s0", 0, 8'h00, 1);
    drv_b(1, 0, 8'hB1); tick();
    st_b("fw_s1", 1, 8'hB0, 2);
    for (int k = 1; k <= 12; k++) begin
      drv_b(1, 1, 8'(8'hB0 + k + 1)); tick();
      st_b("fw_sus", 1, 8'(8'hB0 + k), 2);
    end
    drv_b(0, 1, 8'h00); tick();
    st_b("fw_dr1", 1, 8'hBD, 1);
    tick();
    st_b("fw_dr0", 0, 8'h00, 0);

    // Show-ahead fill to full; rd+wr at full drops the write
    for (int i = 0; i < 4; i++) begin
      drv_b(1, 0, 8'(8'hE0 + i)); tick();
      st_b("fw_fill", i > 0, 8'hE0, i + 1);
    end
    drv_b(1, 1, 8'hE4); tick();
    st_b("fw_rwfull", 1, 8'hE1, 3);
    check("fw_rwfull.ovf", 32'(ifb.ovf), 32'(ERR));
    for (int i = 0; i < 2; i++) begin
      drv_b(0, 1, 8'h00); tick();
      st_b("fw_drain", 1, 8'(8'hE2 + i), 2 - i);
    end
    tick();
    st_b("fw_last", 0, 8'h00, 0);
    drv_b(0, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
